// File: rtl/ethernet_rx_slot_buffer.sv
// ethernet_rx_slot_buffer
//
// Multi-slot receive packet buffer between the MAC receive AXI-Stream and a
// memory-mapped packet read port. Up to slots_p complete frames are queued in
// FIFO order inside one 1R1W synchronous RAM. Each slot holds eth_mtu_p bytes.
// Frames are never backpressured. A frame is dropped when all slots are full.
// A frame is discarded when it is flagged bad by tuser, is oversize, or has
// zero length.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   rx_axis_t*                receive stream (tready is always 1)
//   packet_avail_o            at least one committed frame is queued
//   packet_rsize_o            byte length of the head frame (0 when empty)
//   packet_rvalid_i           read request at byte offset packet_raddr_i
//   packet_rdata_size_i       log2 of the access size in bytes
//   packet_rdata_o            registered read data, right-justified, zero-extended
//   packet_ack_i              pop the head frame
//   slots_used_o              number of committed frames
//   drop_count_o              frames dropped while full (saturating)
//   bad_count_o               frames discarded as bad (saturating)
module ethernet_rx_slot_buffer #(
    parameter int data_width_p = 32,
    parameter int eth_mtu_p    = 2048,
    parameter int slots_p      = 4,
    localparam int size_width_lp = $clog2(eth_mtu_p + 1),
    localparam int addr_width_lp = $clog2(eth_mtu_p),
    localparam int op_width_lp   = $clog2($clog2(data_width_p / 8) + 1),
    localparam int used_width_lp = $clog2(slots_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [data_width_p-1:0]   rx_axis_tdata_i,
    input  logic [data_width_p/8-1:0] rx_axis_tkeep_i,
    input  logic                      rx_axis_tvalid_i,
    output logic                      rx_axis_tready_o,
    input  logic                      rx_axis_tlast_i,
    input  logic                      rx_axis_tuser_i,
    output logic                      packet_avail_o,
    output logic [size_width_lp-1:0]  packet_rsize_o,
    input  logic                      packet_rvalid_i,
    input  logic [addr_width_lp-1:0]  packet_raddr_i,
    input  logic [op_width_lp-1:0]    packet_rdata_size_i,
    output logic [data_width_p-1:0]   packet_rdata_o,
    input  logic                      packet_ack_i,
    output logic [used_width_lp-1:0]  slots_used_o,
    output logic [15:0]               drop_count_o,
    output logic [15:0]               bad_count_o
);

    localparam int bytes_lp          = data_width_p / 8;
    localparam int lg_bytes_lp       = $clog2(bytes_lp);
    localparam int slot_width_lp     = $clog2(slots_p);
    localparam int word_off_width_lp = addr_width_lp - lg_bytes_lp;
    localparam int ram_addr_width_lp = slot_width_lp + word_off_width_lp;
    localparam int ram_words_lp      = slots_p * eth_mtu_p / bytes_lp;

    localparam logic [size_width_lp:0]   mtu_c      = (size_width_lp + 1)'(eth_mtu_p);
    localparam logic [size_width_lp:0]   bcnt_one_c = (size_width_lp + 1)'(1);
    localparam logic [used_width_lp-1:0] slots_c    = used_width_lp'(slots_p);
    localparam logic [used_width_lp-1:0] used_one_c = used_width_lp'(1);
    localparam logic [slot_width_lp-1:0] slot_one_c = slot_width_lp'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP_FULL,
        ST_DROP_BAD
    } state_e;

    state_e                     state_reg, state_next;
    logic [size_width_lp:0]     bcnt_reg, bcnt_next;
    logic [size_width_lp:0]     beat_bytes, bcnt_sum;
    logic [slot_width_lp-1:0]   wr_slot_reg, rd_slot_reg;
    logic [used_width_lp-1:0]   used_reg;
    logic [15:0]                drop_count_reg, bad_count_reg;

    logic [data_width_p-1:0]    ram_mem [ram_words_lp];
    logic [size_width_lp-1:0]   size_mem [slots_p];
    logic [data_width_p-1:0]    ram_q_reg;
    logic [lg_bytes_lp-1:0]     rd_lane_reg;
    logic [op_width_lp-1:0]     rd_size_reg;
    logic                       rdata_live_reg;

    logic                       accept, wr_en, commit, bad_inc, drop_inc;
    logic                       full, ack_fire, rd_fire;
    logic [ram_addr_width_lp-1:0] wr_addr, rd_addr;
    logic [data_width_p-1:0]    rd_shift, rd_mask;

    assign rx_axis_tready_o = 1'b1;

    // Full is judged on the registered count, so a same-cycle ack does not
    // free a slot for the frame starting in that cycle.
    assign full     = (used_reg == slots_c);
    assign ack_fire = packet_ack_i && (used_reg != '0);
    assign rd_fire  = packet_rvalid_i && (used_reg != '0);

    // tkeep is contiguous from bit 0, so the running byte count is also the
    // byte offset of the current beat within the slot.
    assign wr_addr = {wr_slot_reg, bcnt_reg[addr_width_lp-1:lg_bytes_lp]};
    assign rd_addr = {rd_slot_reg, packet_raddr_i[addr_width_lp-1:lg_bytes_lp]};

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < bytes_lp; i++) begin
            if (rx_axis_tkeep_i[i]) beat_bytes = beat_bytes + bcnt_one_c;
        end
    end

    assign bcnt_sum = bcnt_reg + beat_bytes;

    // Write FSM: state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_reg <= ST_IDLE;
        else            state_reg <= state_next;
    end

    // Write FSM: next state and per-beat controls
    always_comb begin
        state_next = state_reg;
        bcnt_next  = bcnt_reg;
        accept     = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        bad_inc    = 1'b0;
        drop_inc   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_axis_tvalid_i) begin
                    if (full) begin
                        drop_inc   = rx_axis_tlast_i;
                        state_next = rx_axis_tlast_i ? ST_IDLE : ST_DROP_FULL;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (rx_axis_tvalid_i) begin
                    if (bcnt_sum > mtu_c) begin
                        bad_inc    = 1'b1;
                        bcnt_next  = '0;
                        state_next = rx_axis_tlast_i ? ST_IDLE : ST_DROP_BAD;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            ST_DROP_FULL: begin
                if (rx_axis_tvalid_i && rx_axis_tlast_i) begin
                    drop_inc   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DROP_BAD: begin
                if (rx_axis_tvalid_i && rx_axis_tlast_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (accept) begin
            wr_en = 1'b1;
            if (rx_axis_tlast_i) begin
                if (rx_axis_tuser_i || (bcnt_sum == '0)) bad_inc = 1'b1;
                else                                      commit  = 1'b1;
                bcnt_next  = '0;
                state_next = ST_IDLE;
            end else begin
                bcnt_next  = bcnt_sum;
                state_next = ST_RECV;
            end
        end
    end

    // Pointers, occupancy, counters and read-side control
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bcnt_reg       <= '0;
            wr_slot_reg    <= '0;
            rd_slot_reg    <= '0;
            used_reg       <= '0;
            drop_count_reg <= '0;
            bad_count_reg  <= '0;
            rd_lane_reg    <= '0;
            rd_size_reg    <= '0;
            rdata_live_reg <= 1'b0;
        end else begin
            bcnt_reg <= bcnt_next;
            if (commit)   wr_slot_reg <= wr_slot_reg + slot_one_c;
            if (ack_fire) rd_slot_reg <= rd_slot_reg + slot_one_c;
            case ({commit, ack_fire})
                2'b10:   used_reg <= used_reg + used_one_c;
                2'b01:   used_reg <= used_reg - used_one_c;
                default: used_reg <= used_reg;
            endcase
            if (drop_inc && (drop_count_reg != 16'hFFFF)) drop_count_reg <= drop_count_reg + 16'd1;
            if (bad_inc && (bad_count_reg != 16'hFFFF))   bad_count_reg  <= bad_count_reg + 16'd1;
            if (rd_fire) begin
                rd_lane_reg    <= packet_raddr_i[lg_bytes_lp-1:0];
                rd_size_reg    <= packet_rdata_size_i;
                rdata_live_reg <= 1'b1;
            end
        end
    end

    // Frame RAM: one write port, one registered read port. The read register
    // only loads on an accepted request, so ignored reads hold the output.
    always_ff @(posedge clk_i) begin
        if (wr_en)   ram_mem[wr_addr] <= rx_axis_tdata_i;
        if (rd_fire) ram_q_reg        <= ram_mem[rd_addr];
    end

    always_ff @(posedge clk_i) begin
        if (commit) size_mem[wr_slot_reg] <= bcnt_sum[size_width_lp-1:0];
    end

    // Lane select on the registered RAM word; rdata_live_reg forces zero until
    // the first read after reset, since the RAM output register has no reset.
    assign rd_shift = ram_q_reg >> {rd_lane_reg, 3'b000};

    for (genvar gi = 0; gi < data_width_p; gi++) begin : g_rd_mask
        assign rd_mask[gi] = (gi < (8 << rd_size_reg));
    end

    assign packet_rdata_o = rdata_live_reg ? (rd_shift & rd_mask) : '0;

    assign packet_avail_o = (used_reg != '0);
    assign packet_rsize_o = packet_avail_o ? size_mem[rd_slot_reg] : '0;
    assign slots_used_o   = used_reg;
    assign drop_count_o   = drop_count_reg;
    assign bad_count_o    = bad_count_reg;

endmodule

// File: tb/tb_ethernet_rx_slot_buffer.sv
// Directed testbench for ethernet_rx_slot_buffer (32-bit data, 2048-byte
// slots, 4 slots). Inputs are driven 1 ns after the rising edge and outputs
// are sampled at the same point, so every check sees the state after an edge.
module tb_ethernet_rx_slot_buffer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] rx_axis_tdata_i;
    logic [3:0]  rx_axis_tkeep_i;
    logic        rx_axis_tvalid_i;
    logic        rx_axis_tready_o;
    logic        rx_axis_tlast_i;
    logic        rx_axis_tuser_i;
    logic        packet_avail_o;
    logic [11:0] packet_rsize_o;
    logic        packet_rvalid_i;
    logic [10:0] packet_raddr_i;
    logic [1:0]  packet_rdata_size_i;
    logic [31:0] packet_rdata_o;
    logic        packet_ack_i;
    logic [2:0]  slots_used_o;
    logic [15:0] drop_count_o;
    logic [15:0] bad_count_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    int q_size[$];
    int q_tag[$];

    always #5 clk_i = ~clk_i;

    ethernet_rx_slot_buffer #(
        .data_width_p(32),
        .eth_mtu_p   (2048),
        .slots_p     (4)
    ) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .rx_axis_tdata_i    (rx_axis_tdata_i),
        .rx_axis_tkeep_i    (rx_axis_tkeep_i),
        .rx_axis_tvalid_i   (rx_axis_tvalid_i),
        .rx_axis_tready_o   (rx_axis_tready_o),
        .rx_axis_tlast_i    (rx_axis_tlast_i),
        .rx_axis_tuser_i    (rx_axis_tuser_i),
        .packet_avail_o     (packet_avail_o),
        .packet_rsize_o     (packet_rsize_o),
        .packet_rvalid_i    (packet_rvalid_i),
        .packet_raddr_i     (packet_raddr_i),
        .packet_rdata_size_i(packet_rdata_size_i),
        .packet_rdata_o     (packet_rdata_o),
        .packet_ack_i       (packet_ack_i),
        .slots_used_o       (slots_used_o),
        .drop_count_o       (drop_count_o),
        .bad_count_o        (bad_count_o)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] byte_val(input int tag, input int idx);
        return 8'((tag * 37 + idx * 3 + 1) & 255);
    endfunction

    function automatic logic [31:0] word_at(input int tag, input int off);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = byte_val(tag, off + i);
        return w;
    endfunction

    // Sends one frame of nbytes back-to-back beats; a zero-byte frame is a
    // single tlast beat with tkeep=0. Optionally asserts ack on the tlast beat.
    task automatic send_frame(input int nbytes, input int tag, input bit user, input bit ack_last);
        int nbeats;
        int rem;
        nbeats = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
        for (int b = 0; b < nbeats; b++) begin
            rem = nbytes - 4 * b;
            for (int i = 0; i < 4; i++) rx_axis_tkeep_i[i] = (i < rem);
            rx_axis_tdata_i  = word_at(tag, 4 * b);
            rx_axis_tvalid_i = 1'b1;
            rx_axis_tlast_i  = (b == nbeats - 1);
            rx_axis_tuser_i  = (b == nbeats - 1) ? user : 1'b0;
            packet_ack_i     = (b == nbeats - 1) && ack_last;
            tick();
        end
        rx_axis_tvalid_i = 1'b0;
        rx_axis_tlast_i  = 1'b0;
        rx_axis_tuser_i  = 1'b0;
        packet_ack_i     = 1'b0;
    endtask

    task automatic read_word(input int addr, input int sz);
        packet_raddr_i      = 11'(addr);
        packet_rdata_size_i = 2'(sz);
        packet_rvalid_i     = 1'b1;
        tick();
        packet_rvalid_i     = 1'b0;
    endtask

    task automatic ack_head();
        packet_ack_i = 1'b1;
        tick();
        packet_ack_i = 1'b0;
    endtask

    initial begin
        reset_n_i           = 1'b0;
        rx_axis_tdata_i     = '0;
        rx_axis_tkeep_i     = '0;
        rx_axis_tvalid_i    = 1'b0;
        rx_axis_tlast_i     = 1'b0;
        rx_axis_tuser_i     = 1'b0;
        packet_rvalid_i     = 1'b0;
        packet_raddr_i      = '0;
        packet_rdata_size_i = '0;
        packet_ack_i        = 1'b0;

        // Reset state
        repeat (3) tick();
        reset_n_i = 1'b1;
        tick();
        check_value("rst_avail", packet_avail_o, 0);
        check_value("rst_rsize", packet_rsize_o, 0);
        check_value("rst_rdata", packet_rdata_o, 0);
        check_value("rst_used",  slots_used_o, 0);
        check_value("rst_drop",  drop_count_o, 0);
        check_value("rst_bad",   bad_count_o, 0);
        check_value("rst_tready", rx_axis_tready_o, 1);

        // 64-byte frame, back-to-back word reads
        send_frame(64, 1, 1'b0, 1'b0);
        check_value("f64_avail", packet_avail_o, 1);
        check_value("f64_rsize", packet_rsize_o, 64);
        check_value("f64_used",  slots_used_o, 1);
        packet_rvalid_i     = 1'b1;
        packet_rdata_size_i = 2'd2;
        for (int o = 0; o < 64; o += 4) begin
            packet_raddr_i = 11'(o);
            tick();
            check_value($sformatf("f64_rd%0d", o), packet_rdata_o, word_at(1, o));
        end
        packet_rvalid_i = 1'b0;
        ack_head();
        check_value("f64_ack_avail", packet_avail_o, 0);
        check_value("f64_ack_used",  slots_used_o, 0);
        check_value("f64_ack_rsize", packet_rsize_o, 0);
        // Read while empty is ignored; output holds the last word
        read_word(0, 2);
        check_value("empty_rd_hold", packet_rdata_o, word_at(1, 60));

        // 61-byte frame, sub-word reads
        send_frame(61, 2, 1'b0, 1'b0);
        check_value("f61_rsize", packet_rsize_o, 61);
        read_word(60, 0);
        check_value("f61_b60", packet_rdata_o, {24'h0, byte_val(2, 60)});
        read_word(2, 1);
        check_value("f61_h2", packet_rdata_o, {16'h0, byte_val(2, 3), byte_val(2, 2)});
        read_word(5, 0);
        check_value("f61_b5", packet_rdata_o, {24'h0, byte_val(2, 5)});
        ack_head();

        // Fill: fifth frame finds all slots used and is dropped
        for (int k = 0; k < 5; k++) send_frame(100 * (k + 1), 10 + k, 1'b0, 1'b0);
        check_value("fill_used", slots_used_o, 4);
        check_value("fill_drop", drop_count_o, 1);
        check_value("fill_bad",  bad_count_o, 0);
        read_word(96, 2);
        check_value("fill_rd96", packet_rdata_o, word_at(10, 96));
        for (int k = 0; k < 4; k++) begin
            check_value($sformatf("fill_rsize%0d", k), packet_rsize_o, 100 * (k + 1));
            read_word(0, 2);
            check_value($sformatf("fill_rd0_%0d", k), packet_rdata_o, word_at(10 + k, 0));
            ack_head();
        end
        check_value("fill_empty_used",  slots_used_o, 0);
        check_value("fill_empty_avail", packet_avail_o, 0);

        // Bad frames
        send_frame(64, 20, 1'b1, 1'b0);
        check_value("tuser_bad",   bad_count_o, 1);
        check_value("tuser_avail", packet_avail_o, 0);
        send_frame(2052, 21, 1'b0, 1'b0);
        check_value("over2052_bad",  bad_count_o, 2);
        check_value("over2052_used", slots_used_o, 0);
        send_frame(2060, 25, 1'b0, 1'b0);
        check_value("over2060_bad",  bad_count_o, 3);
        send_frame(64, 22, 1'b0, 1'b0);
        check_value("after_bad_rsize", packet_rsize_o, 64);
        read_word(0, 2);
        check_value("after_bad_rd0", packet_rdata_o, word_at(22, 0));
        ack_head();
        send_frame(0, 23, 1'b0, 1'b0);
        check_value("zero_len_bad",   bad_count_o, 4);
        check_value("zero_len_avail", packet_avail_o, 0);
        send_frame(2048, 24, 1'b0, 1'b0);
        check_value("mtu_rsize", packet_rsize_o, 2048);
        check_value("mtu_bad",   bad_count_o, 4);
        read_word(2044, 2);
        check_value("mtu_rdlast", packet_rdata_o, word_at(24, 2044));
        ack_head();
        check_value("bad_drop_unchanged", drop_count_o, 1);

        // Simultaneous commit and ack, then wrap across 9 more frames
        send_frame(40, 30, 1'b0, 1'b0);
        send_frame(48, 31, 1'b0, 1'b0);
        check_value("sim_used_pre", slots_used_o, 2);
        send_frame(52, 32, 1'b0, 1'b1);
        check_value("sim_used",  slots_used_o, 2);
        check_value("sim_rsize", packet_rsize_o, 48);
        q_size = '{48, 52};
        q_tag  = '{31, 32};
        for (int k = 0; k < 9; k++) begin
            send_frame(4 * (k + 5), 40 + k, 1'b0, 1'b1);
            q_size.push_back(4 * (k + 5));
            q_tag.push_back(40 + k);
            void'(q_size.pop_front());
            void'(q_tag.pop_front());
            check_value($sformatf("wrap%0d_used", k), slots_used_o, 2);
            check_value($sformatf("wrap%0d_rsize", k), packet_rsize_o, q_size[0]);
            read_word(0, 2);
            check_value($sformatf("wrap%0d_rd0", k), packet_rdata_o, word_at(q_tag[0], 0));
        end
        // A read in the ack cycle returns the old head
        packet_raddr_i      = 11'd4;
        packet_rdata_size_i = 2'd2;
        packet_rvalid_i     = 1'b1;
        packet_ack_i        = 1'b1;
        tick();
        packet_rvalid_i = 1'b0;
        packet_ack_i    = 1'b0;
        check_value("ackrd_old_head", packet_rdata_o, word_at(q_tag[0], 4));
        check_value("ackrd_rsize",    packet_rsize_o, q_size[1]);
        check_value("ackrd_used",     slots_used_o, 1);
        ack_head();
        check_value("drain_used", slots_used_o, 0);

        // Asynchronous reset mid-frame with 3 frames queued
        send_frame(16, 50, 1'b0, 1'b0);
        send_frame(20, 51, 1'b0, 1'b0);
        send_frame(24, 52, 1'b0, 1'b0);
        check_value("prerst_used", slots_used_o, 3);
        read_word(0, 2);
        rx_axis_tkeep_i  = 4'hF;
        rx_axis_tvalid_i = 1'b1;
        rx_axis_tlast_i  = 1'b0;
        rx_axis_tdata_i  = word_at(53, 0);
        tick();
        rx_axis_tdata_i  = word_at(53, 4);
        tick();
        #3;
        reset_n_i = 1'b0;
        #1;
        check_value("arst_avail", packet_avail_o, 0);
        check_value("arst_used",  slots_used_o, 0);
        check_value("arst_rsize", packet_rsize_o, 0);
        check_value("arst_rdata", packet_rdata_o, 0);
        check_value("arst_drop",  drop_count_o, 0);
        check_value("arst_bad",   bad_count_o, 0);
        check_value("arst_tready", rx_axis_tready_o, 1);
        rx_axis_tvalid_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();
        send_frame(32, 60, 1'b0, 1'b0);
        check_value("postrst_used",  slots_used_o, 1);
        check_value("postrst_rsize", packet_rsize_o, 32);
        read_word(0, 2);
        check_value("postrst_rd0",  packet_rdata_o, word_at(60, 0));
        read_word(28, 2);
        check_value("postrst_rd28", packet_rdata_o, word_at(60, 28));
        check_value("postrst_bad",  bad_count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ethernet_rx_slot_buffer.md
# ethernet_rx_slot_buffer

Multi-slot receive packet buffer for the Ethernet controller. It replaces the single-packet receive buffer between the MAC's receive AXI-Stream and the memory-mapped packet read interface. Up to `slots_p` complete frames are queued in FIFO order. Frames are dropped, never backpressured, when the buffer is full or a frame is bad, and drop and bad-frame counters are exposed for the debug register space.

## Interface
- `data_width_p`, 32: AXIS and read data width in bits; legal values 32 or 64.
- `eth_mtu_p`, 2048: bytes per slot; a power of two.
- `slots_p`, 4: number of frame slots; a power of two, at least 2.
- Derived: `size_width_lp = $clog2(eth_mtu_p+1)`, `addr_width_lp = $clog2(eth_mtu_p)`, `op_width_lp = BSG_WIDTH(clog2(data_width_p/8))`.
- `clk_i`  in  1  the single clock for the whole block.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `rx_axis_tdata_i`  in  `data_width_p`  frame data; byte 0 is in the LSBs.
- `rx_axis_tkeep_i`  in  `data_width_p/8`  byte enables, contiguous from bit 0.
- `rx_axis_tvalid_i`  in  1  beat valid.
- `rx_axis_tready_o`  out  1  held at 1 after reset.
- `rx_axis_tlast_i`  in  1  last beat of the frame.
- `rx_axis_tuser_i`  in  1  bad frame, sampled on the tlast beat.
- `packet_avail_o`  out  1  at least one committed frame is queued.
- `packet_rsize_o`  out  `size_width_lp`  byte length of the head frame.
- `packet_rvalid_i`  in  1  read request.
- `packet_raddr_i`  in  `addr_width_lp`  byte offset into the head frame.
- `packet_rdata_size_i`  in  `op_width_lp`  log2 of the access size in bytes.
- `packet_rdata_o`  out  `data_width_p`  read data, right-justified and zero-extended.
- `packet_ack_i`  in  1  pop the head frame.
- `slots_used_o`  out  `$clog2(slots_p+1)`  count of committed frames.
- `drop_count_o`  out  16  frames dropped because the buffer was full; saturating.
- `bad_count_o`  out  16  frames discarded for tuser, oversize or zero length; saturating.

## Operation
- **Storage:** one 1R1W synchronous RAM of `slots_p*eth_mtu_p/(data_width_p/8)` words. Word address is `{slot, offset[addr_width_lp-1:log2(bytes per word)]}`.
- **Pointers and count:** `wr_slot` and `rd_slot` are `log2(slots_p)`-bit pointers that wrap naturally. `used` counts committed frames, 0..`slots_p`.
- **Write FSM, IDLE:**
  - On a beat with `used==slots_p`, evaluated before any same-cycle ack: go to DROP_FULL.
  - Otherwise write the beat at offset 0 and go to RECV.
  - A beat that is both first and last is handled with the tlast rules below.
- **Write FSM, RECV:**
  - Each beat writes word `offset/bytes per word` and adds popcount(tkeep) to the byte count `bcnt` (`size_width_lp+1` bits).
  - If `bcnt` would exceed `eth_mtu_p`, the beat is not written: go to DROP_BAD, or to IDLE if the beat is tlast. Count one bad frame in either case.
- **tlast beat, commit or discard:**
  - If `tuser=1` or the final `bcnt` is 0: discard, `bad_count` +1.
  - Otherwise commit: record `size[wr_slot]=bcnt`, increment `wr_slot`, increment `used`.
  - In all cases return to IDLE and clear `bcnt`.
- **DROP_FULL / DROP_BAD:** consume beats without writing; on tlast return to IDLE. DROP_FULL increments `drop_count` exactly once per frame, on tlast.
- **Read:**
  - `packet_rvalid_i` reads the word at `{rd_slot, raddr}`.
  - `2^rdata_size` bytes are selected starting at byte lane `raddr mod bytes per word`, right-justified, with upper bits zero.
  - `raddr` must be aligned to the access size.
  - If `packet_avail_o=0`, the request is ignored and `packet_rdata_o` holds its value.
- **Ack:** `packet_ack_i` with `used>0` increments `rd_slot` and decrements `used`. Ack with `used==0` is ignored.
- **Simultaneous commit and ack:** `used` is unchanged and both pointers advance.
- **Counters:** saturate at 16'hFFFF.
- **Reset (`reset_n_i` low, any time):**
  - Pointers, `used`, `bcnt`, both counters and `packet_rdata_o` clear to 0; FSM returns to IDLE; `rx_axis_tready_o` goes to 1.
  - Size array contents are don't-care.
  - A frame in flight is lost. The MAC must be reset in the same domain.

## Timing
- Reset values: `packet_avail_o=0`, `packet_rsize_o=0`, `packet_rdata_o=0`, `slots_used_o=0`, `drop_count_o=0`, `bad_count_o=0`, `rx_axis_tready_o=1`.
- `rx_axis_tready_o` is constant 1; every tvalid cycle is an accepted beat.
- **Commit visibility:** `packet_avail_o`, `packet_rsize_o` and `slots_used_o` update on the clock edge that accepts the tlast beat, so they are visible in the next cycle.
- **Read latency:** `packet_rdata_o` is registered and valid 1 cycle after `packet_rvalid_i`. Back-to-back reads every cycle are supported.
- **Ack:** takes effect on the same edge. `packet_rsize_o` shows the next frame's size in the following cycle; a read issued in the ack cycle returns data from the old head.
- No combinational path from any input to any output.

## Test plan
- Reset, then one 64-byte good frame (16 beats, all tkeep=4'hF) -> `packet_avail_o=1` and `packet_rsize_o=64` the cycle after tlast. Reads at offsets 0..60 with size 2 return the sent words 1 cycle later. Ack -> `packet_avail_o=0`, `slots_used_o=0`.
- Sub-word reads: frame of 61 bytes (last tkeep=4'h1) -> `rsize=61`. Size-0 read at offset 60 returns byte 60 in [7:0] with upper bits zero; a size-1 read at offset 2 returns bytes 2..3.
- Fill: 5 back-to-back frames of 100, 200, 300, 400 and 500 bytes, no ack -> `slots_used_o=4`, `drop_count_o=1`. Sizes read in FIFO order 100, 200, 300, 400 across 4 acks.
- Bad frames:
  - Tuser=1 on tlast -> `bad_count_o=1`, nothing queued.
  - 2052-byte frame -> `bad_count_o=2`.
  - A following 64-byte good frame is still committed, with `rsize=64`.
- Simultaneous tlast of a good frame and ack with `used=2` -> `used` stays 2; head advances; new size stored in the correct slot; wrap verified over 9 frames.
- Assert `reset_n_i` mid-frame, after 3 queued frames -> all outputs at reset values immediately (asynchronous). The next full frame is committed as slot 0.
